regfile_wb_queue: RTL
=====================

Name: regfile_wb_queue

Overview:
- Write-side driver for the RV32I register file. Buffers register writebacks (rd, data) from the execute/load datapath in a small FIFO.
- Drains the FIFO into the regfile write port (we, rd, wrs3) one entry per cycle.
- Provides two forwarding lookups so rs1/rs2 readers see pending writes before they reach the regfile.
- Sits between the writeback mux and the regfile write port.

Parameters:
- DEPTH, 4, number of queued writebacks; power of two, 2..16.
- AW, 2, pointer width, log2(DEPTH).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- in_valid  input  1  writeback beat offered.
- in_ready  output  1  queue can accept a beat.
- in_rd  input  5  destination register.
- in_data  input  32  value to write.
- rf_stall  input  1  regfile write port unavailable this cycle.
- rf_we  output  1  regfile write enable.
- rf_rd  output  5  regfile write address.
- rf_wrs3  output  32  regfile write data.
- q_rs1  input  5  forwarding query 1.
- q_rs2  input  5  forwarding query 2.
- fwd1_hit  output  1  q_rs1 has a pending write.
- fwd1_data  output  32  newest pending value for q_rs1.
- fwd2_hit  output  1  q_rs2 has a pending write.
- fwd2_data  output  32  newest pending value for q_rs2.
- count  output  AW+1  entries held.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.

Behaviour:
- Reset (reset = 0, asynchronous):
  - Read/write pointers and count cleared; all queued writes dropped, including mid-drain.
  - Outputs while in reset: rf_we = 0, rf_rd = 0, rf_wrs3 = 0, fwd*_hit = 0, fwd*_data = 0, count = 0, empty = 1, full = 0, in_ready = 1.
  - Storage array contents need not be cleared.
- Accept:
  - Beat accepted when in_valid && in_ready at the clock edge.
  - in_ready = !full. No pass-through when full, even if a drain occurs in the same cycle.
- x0 filter: an accepted beat with in_rd == 0 is consumed (handshake completes) but not stored; count is unchanged.
- Drain:
  - rf_we = !empty && !rf_stall, combinational.
  - rf_rd and rf_wrs3 show the head entry whenever !empty, and 0 when empty.
  - The head pops at the edge where rf_we = 1; the regfile captures the write on that same edge.
- Latency: a beat accepted at edge N into an empty queue drives rf_we = 1 during cycle N+1, unless stalled.
- Ordering: strict FIFO. Writes to the same rd reach the regfile in acceptance order.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pointer wrap: pointers are AW bits and wrap from DEPTH-1 to 0. count distinguishes full from empty.
- Forwarding (combinational):
  - Search valid entries only, newest to oldest; the first match on rd gives fwdN_data.
  - The head being drained this cycle still counts as a hit.
  - The incoming (not yet accepted) beat is never forwarded.
  - q_rsN == 0 never hits.
  - On a miss, fwdN_data = 0.
- rf_stall held high: the queue fills. At count == DEPTH, in_ready drops. Contents are held indefinitely; no overflow, no data loss.
- No state machine beyond the FIFO. Control is counter/pointer based.

Decomposition:
- Shared package rv32i_pkg:
  - REG_AW = 5, XLEN = 32.
  - Typedef wb_entry_t {rd[4:0], data[31:0]}.
- One natural sub-module: wbq_fwd_lookup, a combinational newest-first match over DEPTH entries, instantiated twice (rs1 and rs2).
- FIFO storage and pointers stay in regfile_wb_queue.

Test Plan:
- Reset then idle: hold reset = 0 for 2 cycles, release -> rf_we = 0, empty = 1, in_ready = 1, count = 0; fwd1_hit = 0 for q_rs1 = 3.
- Single write: push (rd = 3, data = 16), rf_stall = 0 -> next cycle rf_we = 1, rf_rd = 3, rf_wrs3 = 16; the regfile reads back 16 at rs1 = 3; then empty = 1.
- Fill under stall: rf_stall = 1, push rd 1..5 with data 0x11..0x15 -> 4 accepted, full = 1, in_ready = 0 on the 5th beat. Release the stall -> rf_rd sequence 1, 2, 3, 4 with data 0x11..0x14 on consecutive cycles.
- Forwarding priority: rf_stall = 1, push (5, 0xA) then (5, 0xB), q_rs1 = 5, q_rs2 = 0 -> fwd1_hit = 1, fwd1_data = 0xB; fwd2_hit = 0.
- x0 discard plus wrap:
  - Push (0, 0xFFFF) -> handshake completes, count stays 0, rf_we never asserts.
  - Then 10 push/pop pairs with rd = 7 and data 0..9 -> pointers wrap; the final regfile value of x7 is 9.
- Reset mid-operation: 3 entries queued with the stall high, then pulse reset = 0 -> count = 0, rf_we = 0, fwd hits cleared; after release no stale write reaches the regfile.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I register-file types used by the writeback queue and its forwarding lookup.
package rv32i_pkg;

    localparam int REG_AW = 5;
    localparam int XLEN   = 32;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/wbq_fwd_lookup.sv
// Combinational newest-first search of the valid queue entries for one source register.
module wbq_fwd_lookup
    import rv32i_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  wb_entry_t [DEPTH-1:0] entries,
    input  logic [AW-1:0]         rd_ptr,
    input  logic [AW:0]           count,
    input  logic [REG_AW-1:0]     query,
    output logic                  hit,
    output logic [XLEN-1:0]       data
);

    logic [AW-1:0] idx;

    // Walk oldest to newest so the last match wins, i.e. the newest pending value.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + AW'(i);
            if (((AW+1)'(i) < count) && (query != '0) && (entries[idx].rd == query)) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_queue.sv
// Writeback FIFO in front of the RV32I regfile write port, with two forwarding lookups
// so readers see writes that are still queued.
module regfile_wb_queue
    import rv32i_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [XLEN-1:0]   in_data,
    input  logic              rf_stall,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_rd,
    output logic [XLEN-1:0]   rf_wrs3,
    input  logic [REG_AW-1:0] q_rs1,
    input  logic [REG_AW-1:0] q_rs2,
    output logic              fwd1_hit,
    output logic [XLEN-1:0]   fwd1_data,
    output logic              fwd2_hit,
    output logic [XLEN-1:0]   fwd2_data,
    output logic [AW:0]       count,
    output logic              empty,
    output logic              full
);

    wb_entry_t [DEPTH-1:0] mem;
    wb_entry_t             head;
    logic [AW-1:0]         rd_ptr;
    logic [AW-1:0]         wr_ptr;
    logic                  push;
    logic                  pop;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign in_ready = !full;

    // Writes to x0 complete the handshake but are never stored.
    assign push = in_valid && in_ready && (in_rd != '0);
    assign pop  = rf_we;

    assign head    = mem[rd_ptr];
    assign rf_we   = !empty && !rf_stall;
    assign rf_rd   = empty ? '0 : head.rd;
    assign rf_wrs3 = empty ? '0 : head.data;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_rd, in_data};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    wbq_fwd_lookup #(.DEPTH(DEPTH), .AW(AW)) u_fwd1 (
        .entries (mem),
        .rd_ptr  (rd_ptr),
        .count   (count),
        .query   (q_rs1),
        .hit     (fwd1_hit),
        .data    (fwd1_data)
    );

    wbq_fwd_lookup #(.DEPTH(DEPTH), .AW(AW)) u_fwd2 (
        .entries (mem),
        .rd_ptr  (rd_ptr),
        .count   (count),
        .query   (q_rs2),
        .hit     (fwd2_hit),
        .data    (fwd2_data)
    );

endmodule
